multicycle_ctrl_ws: RTL

// Parametrised successor of the multicycle MIPS control unit. Same datapath strobes, plus:
// - variable-latency memory via MemReq/MemReady handshake (wait states), with timeout;
// - addi and j support, PC source select, and an error TRAP state.

---
 rtl/multicycle_ctrl_ws.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_ws.sv
// Multicycle MIPS control unit with memory wait states, timeout and TRAP.
// Decodes lw/sw/R/beq/j/addi into datapath strobes and mux selects.
module multicycle_ctrl_ws #(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter int unsigned CNT_W           = 5,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       CtrMem,
    output logic       IouD,
    output logic       IREsc,
    output logic       MDRCtrl,
    output logic       ULASaidaCtrl,
    output logic       PCEsc,
    output logic [1:0] PCSrc,
    output logic       ULAFonteA,
    output logic [1:0] ULAFonteB,
    output logic [1:0] ULAOp,
    output logic       RegDst,
    output logic       MemParaReg,
    output logic       RegWrite,
    output logic       Error,
    output logic [3:0] Estado
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam bit TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_st;
    logic             timeout;

    assign wait_st = (state_q == S_FETCH) ||
                     (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

    // MemReady in the last allowed cycle still completes normally
    assign timeout = TO_EN && wait_st && !MemReady &&
                     (cnt_q == CNT_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:
                        state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                state_d = (OpCode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (MemReady) state_d = S_LW_WB;
            end
            S_MEMWRITE: begin
                if (MemReady) state_d = S_FETCH;
            end
            S_LW_WB:     state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
        if (timeout) state_d = S_TRAP;
    end

    // Counter restarts on every state change, so entry clears it
    always_comb begin
        cnt_d = '0;
        if (wait_st && !MemReady && (state_d == state_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        MemReq       = 1'b0;
        CtrMem       = 1'b0;
        IouD         = 1'b0;
        IREsc        = 1'b0;
        MDRCtrl      = 1'b0;
        ULASaidaCtrl = 1'b0;
        PCEsc        = 1'b0;
        PCSrc        = 2'b00;
        ULAFonteA    = 1'b0;
        ULAFonteB    = 2'b00;
        ULAOp        = 2'b00;
        RegDst       = 1'b0;
        MemParaReg   = 1'b0;
        RegWrite     = 1'b0;
        Error        = 1'b0;
        if (!Reset) begin
            // Strobes held off during reset; muxes parked at fetch values
            ULAFonteB = 2'b01;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ULAFonteB = 2'b01;
                    IREsc     = MemReady;
                    PCEsc     = MemReady;
                end
                S_DECODE: begin
                    ULAFonteB    = 2'b11;
                    ULASaidaCtrl = 1'b1;
                end
                S_MEMADDR: begin
                    ULAFonteA    = 1'b1;
                    ULAFonteB    = 2'b10;
                    ULASaidaCtrl = 1'b1;
                end
                S_MEMREAD: begin
                    MemReq  = 1'b1;
                    IouD    = 1'b1;
                    MDRCtrl = MemReady;
                end
                S_LW_WB: begin
                    MemParaReg = 1'b1;
                    RegWrite   = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq = 1'b1;
                    CtrMem = 1'b1;
                    IouD   = 1'b1;
                end
                S_R_EXEC: begin
                    ULAFonteA    = 1'b1;
                    ULAOp        = 2'b10;
                    ULASaidaCtrl = 1'b1;
                end
                S_R_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ULAFonteA = 1'b1;
                    ULAOp     = 2'b01;
                    PCSrc     = 2'b01;
                    PCEsc     = Zero;
                end
                S_JUMP: begin
                    PCSrc = 2'b10;
                    PCEsc = 1'b1;
                end
                S_ADDI_EXEC: begin
                    ULAFonteA    = 1'b1;
                    ULAFonteB    = 2'b10;
                    ULASaidaCtrl = 1'b1;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                S_TRAP: begin
                    Error = 1'b1;
                end
                default: begin
                    Error = 1'b1;
                end
            endcase
        end
    end

    assign Estado = state_q;

endmodule
